spi_agc_master: RTL and testbench

SPI_AGC_MASTER -- requirements
Module: spi_agc_master

---
 rtl/spi_agc_master.sv | 143 ++++++++++++++
 tb/tb_spi_agc_master.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_agc_master.sv
// SPI master for the AGC device: one 16-bit mode-0 frame per start edge,
// command byte then data byte, with readback of the final 8 miso bits.
module spi_agc_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       main_clk,
  input  logic       main_rst_n,
  input  logic [1:0] control_mode,
  input  logic       start,
  input  logic [7:0] spi_mode,
  input  logic [7:0] spi_dataA,
  input  logic [7:0] spi_dataB,
  input  logic       channel,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_a_n,
  output logic       cs_b_n,
  output logic [7:0] read_data,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] SHIFT   = 3'd2;
  localparam logic [2:0] HOLD    = 3'd3;
  localparam logic [2:0] DONE_ST = 3'd4;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  logic [2:0]  state;
  logic        start_d;
  logic [7:0]  cnt;
  logic [3:0]  bit_cnt;
  logic [14:0] sr;
  logic [7:0]  rx;
  logic        rd;
  logic        trigger;
  logic        tick;
  logic [7:0]  wr_byte;

  assign trigger = start & ~start_d
                 & (control_mode == 2'b01)
                 & (state == IDLE);
  assign tick    = (cnt == DIV_M1);
  assign wr_byte = spi_mode[0] ? 8'h00
                 : (channel ? spi_dataB : spi_dataA);

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      state     <= IDLE;
      start_d   <= 1'b0;
      cnt       <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      rx        <= '0;
      rd        <= 1'b0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      cs_a_n    <= 1'b1;
      cs_b_n    <= 1'b1;
      read_data <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      start_d <= start;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (trigger) begin
            state   <= SETUP;
            cnt     <= '0;
            bit_cnt <= '0;
            rd      <= spi_mode[0];
            sr      <= {spi_mode[6:0], wr_byte};
            mosi    <= spi_mode[7];
            cs_a_n  <= channel;
            cs_b_n  <= ~channel;
            busy    <= 1'b1;
          end
        end
        SETUP: begin
          if (tick) begin
            state <= SHIFT;
            cnt   <= '0;
            sclk  <= 1'b1;
            rx    <= {rx[6:0], miso};
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SHIFT: begin
          if (!tick) begin
            cnt <= cnt + 8'd1;
          end else if (sclk) begin
            // falling edge: present the next frame bit
            cnt  <= '0;
            sclk <= 1'b0;
            mosi <= sr[14];
            sr   <= {sr[13:0], 1'b0};
          end else if (bit_cnt == 4'd15) begin
            state <= HOLD;
            cnt   <= '0;
          end else begin
            cnt     <= '0;
            bit_cnt <= bit_cnt + 4'd1;
            sclk    <= 1'b1;
            rx      <= {rx[6:0], miso};
          end
        end
        HOLD: begin
          if (tick) begin
            state  <= DONE_ST;
            cnt    <= '0;
            mosi   <= 1'b0;
            cs_a_n <= 1'b1;
            cs_b_n <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b1;
            if (rd) read_data <= rx;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE_ST: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          sclk   <= 1'b0;
          mosi   <= 1'b0;
          cs_a_n <= 1'b1;
          cs_b_n <= 1'b1;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_agc_master.sv
// Scoreboard bench for spi_agc_master: stimulus pushes expected frames,
// a monitor decodes the SPI lines and checks each completed transaction.
module tb_spi_agc_master;

  localparam int CD = 4;

  logic       main_clk = 1'b0;
  logic       main_rst_n = 1'b0;
  logic [1:0] control_mode = 2'b01;
  logic       start = 1'b0;
  logic [7:0] spi_mode = 8'h00;
  logic [7:0] spi_dataA = 8'h00;
  logic [7:0] spi_dataB = 8'h00;
  logic       channel = 1'b0;
  logic       miso = 1'b0;
  logic       sclk, mosi, cs_a_n, cs_b_n, busy, done;
  logic [7:0] read_data;

  spi_agc_master #(.CLK_DIV(CD)) dut (
    .main_clk(main_clk), .main_rst_n(main_rst_n),
    .control_mode(control_mode), .start(start),
    .spi_mode(spi_mode), .spi_dataA(spi_dataA),
    .spi_dataB(spi_dataB), .channel(channel), .miso(miso),
    .sclk(sclk), .mosi(mosi), .cs_a_n(cs_a_n), .cs_b_n(cs_b_n),
    .read_data(read_data), .busy(busy), .done(done)
  );

  always #5 main_clk = ~main_clk;

  typedef struct {
    logic [15:0] frame;
    logic        ch;
    logic [7:0]  rdata;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  int         done_cnt = 0;
  logic [7:0] miso_byte = 8'h00;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  function automatic logic resp_bit(input int n);
    logic [15:0] r;
    r = {8'h00, miso_byte};
    if (n < 0 || n > 15) return 1'b0;
    return r[15-n];
  endfunction

  // Monitor: device model for miso plus frame decode and checking.
  initial begin
    logic [15:0] cap;
    int          nb, busy_len, a_low, b_low;
    logic        prev_sclk, in_frame, both_low;
    exp_t        e;
    cap = '0; nb = 0; busy_len = 0; a_low = 0; b_low = 0;
    prev_sclk = 0; in_frame = 0; both_low = 0;
    forever begin
      @(negedge main_clk);
      if (!main_rst_n) begin
        in_frame = 0; nb = 0; busy_len = 0; a_low = 0;
        b_low = 0; prev_sclk = 0; both_low = 0; miso = 0;
      end else begin
        if (!cs_a_n && !cs_b_n) both_low = 1;
        if (busy) busy_len++;
        if (!cs_a_n) a_low++;
        if (!cs_b_n) b_low++;
        if (!in_frame && (!cs_a_n || !cs_b_n)) begin
          in_frame = 1; nb = 0; cap = '0;
          miso = resp_bit(0);
        end
        if (in_frame && sclk && !prev_sclk) begin
          cap = {cap[14:0], mosi};
          nb++;
          miso = resp_bit(nb);
        end
        prev_sclk = sclk;
        if (done) begin
          done_cnt++;
          chk("done_expected", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("mosi_frame", 32'(cap), 32'(e.frame));
            chk("bit_count", nb, 16);
            chk("busy_len", busy_len, 34*CD);
            chk("cs_sel_low", e.ch ? b_low : a_low, 34*CD);
            chk("cs_unsel_low", e.ch ? a_low : b_low, 0);
            chk("cs_both_low", 32'(both_low), 32'd0);
            chk("cs_high_done", {cs_a_n, cs_b_n, busy}, 3'b110);
            chk("read_data", 32'(read_data), 32'(e.rdata));
          end
          in_frame = 0; nb = 0; busy_len = 0; a_low = 0;
          b_low = 0; both_low = 0; miso = 0;
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge main_clk); #1 start = 1'b1;
    @(posedge main_clk); #1 start = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge main_clk); n++;
    end
    chk({name, "_timeout"}, sb.size(), 0);
    repeat (3) @(posedge main_clk);
  endtask

  task automatic push(input logic [15:0] f, input logic ch,
                      input logic [7:0] rd);
    exp_t e;
    e.frame = f; e.ch = ch; e.rdata = rd;
    sb.push_back(e);
  endtask

  initial begin
    int   d0;
    logic act;
    // reset values
    #12;
    chk("reset_outs",
        {sclk, mosi, cs_a_n, cs_b_n, busy, done, read_data},
        {6'b001100, 8'h00});
    @(posedge main_clk); #1 main_rst_n = 1'b1;
    repeat (3) @(posedge main_clk);
    chk("idle_outs", {sclk, mosi, cs_a_n, cs_b_n, busy, done},
        6'b001100);

    // write, channel A
    spi_mode = 8'hAA; spi_dataA = 8'hF3; spi_dataB = 8'h11;
    channel = 1'b0;
    push(16'hAAF3, 1'b0, 8'h00);
    pulse_start();
    wait_empty("wr_a");

    // read, channel B
    spi_mode = 8'h25; spi_dataB = 8'h77; channel = 1'b1;
    miso_byte = 8'h5C;
    push(16'h2500, 1'b1, 8'h5C);
    pulse_start();
    wait_empty("rd_b");

    // write B keeps previous readback
    spi_mode = 8'h40; spi_dataB = 8'h3C; miso_byte = 8'hFF;
    push(16'h403C, 1'b1, 8'h5C);
    pulse_start();
    wait_empty("wr_b");

    // wrong control_mode, then start already high on mode change
    d0 = done_cnt; act = 1'b0;
    control_mode = 2'b10;
    @(posedge main_clk); #1 start = 1'b1;
    repeat (20) begin
      @(negedge main_clk);
      if (busy || !cs_a_n || !cs_b_n) act = 1'b1;
    end
    control_mode = 2'b01;
    repeat (200) begin
      @(negedge main_clk);
      if (busy || !cs_a_n || !cs_b_n) act = 1'b1;
    end
    start = 1'b0;
    chk("no_activity", {act, 32'(done_cnt - d0)}, 33'd0);
    repeat (3) @(posedge main_clk);

    // second start edge mid-frame is lost
    d0 = done_cnt;
    spi_mode = 8'hC4; spi_dataA = 8'h96; channel = 1'b0;
    push(16'hC496, 1'b0, 8'h5C);
    pulse_start();
    repeat (48) @(posedge main_clk);
    pulse_start();
    wait_empty("dbl_start");
    repeat (200) @(posedge main_clk);
    chk("one_done", done_cnt - d0, 1);

    // inputs changed mid-frame are ignored
    spi_mode = 8'h5A; spi_dataA = 8'h12; channel = 1'b0;
    push(16'h5A12, 1'b0, 8'h5C);
    pulse_start();
    repeat (30) @(posedge main_clk);
    #1 spi_dataA = 8'hFF; spi_mode = 8'h01; channel = 1'b1;
    control_mode = 2'b11;
    wait_empty("latched");
    control_mode = 2'b01;

    // reset mid-read
    d0 = done_cnt;
    spi_mode = 8'h81; channel = 1'b0; miso_byte = 8'hE7;
    pulse_start();
    repeat (69) @(posedge main_clk);
    #1 main_rst_n = 1'b0;
    #1 chk("abort_outs",
           {sclk, mosi, cs_a_n, cs_b_n, busy, done, read_data},
           {6'b001100, 8'h00});
    repeat (3) @(posedge main_clk);
    #1 main_rst_n = 1'b1;
    repeat (200) @(posedge main_clk);
    #1 chk("abort_no_done", {busy, 32'(done_cnt - d0)}, 33'd0);
    chk("abort_rdata", 32'(read_data), 32'h00);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
